// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID register bank: word map, status and
// control bit positions, and the byte-lane merge used by writable words.
package sysid_pkg;

    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_VERSION   = 3'd2;
    localparam logic [2:0] ADDR_SCRATCH   = 3'd3;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd4;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd5;
    localparam logic [2:0] ADDR_SECONDS   = 3'd6;
    localparam logic [2:0] ADDR_STATUS    = 3'd7;

    // Status word: bit 0 advertises that the uptime/seconds feature exists.
    localparam int STATUS_PRESENT_BIT = 0;

    // Control word (same address as status): writing 1 here clears the timers.
    localparam int CTRL_CLEAR_BIT = 0;

    // Replace only the byte lanes selected by be; keep the others.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sysid_uptime.sv
// Free-running 64-bit cycle counter with a high-word shadow for coherent
// two-word reads, plus a prescaled seconds counter. A clear zeroes all of it.
module sysid_uptime
    import sysid_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 32'd50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        latch_hi,
    output logic [31:0] lo,
    output logic [31:0] hi_shadow,
    output logic [31:0] seconds
);

    localparam int PRESC_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(CLK_FREQ_HZ - 32'sd1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(32'd1);

    logic [63:0]        uptime_r;
    logic [31:0]        hi_shadow_r;
    logic [PRESC_W-1:0] presc_r;
    logic [31:0]        seconds_r;

    // Uptime counter and high-word shadow; clear beats increment and latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            uptime_r    <= 64'd0;
            hi_shadow_r <= 32'd0;
        end else if (clear) begin
            uptime_r    <= 64'd0;
            hi_shadow_r <= 32'd0;
        end else begin
            uptime_r <= uptime_r + 64'd1;
            if (latch_hi) begin
                hi_shadow_r <= uptime_r[63:32];
            end else begin
                hi_shadow_r <= hi_shadow_r;
            end
        end
    end

    // Prescaler divides the clock down to one tick per second for seconds_r.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_r   <= '0;
            seconds_r <= 32'd0;
        end else if (clear) begin
            presc_r   <= '0;
            seconds_r <= 32'd0;
        end else if (presc_r == PRESC_TERM) begin
            presc_r   <= '0;
            seconds_r <= seconds_r + 32'd1;
        end else begin
            presc_r   <= presc_r + PRESC_ONE;
            seconds_r <= seconds_r;
        end
    end

    assign lo        = uptime_r[31:0];
    assign hi_shadow = hi_shadow_r;
    assign seconds   = seconds_r;

endmodule

// File: rtl/sysid_regs.sv
// Avalon-MM slave exposing build identity, a scratch word, uptime and seconds
// as eight 32-bit words. No waitrequest; reads complete with latency 1.
module sysid_regs
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID   = 32'h58C2_F7FF,
    parameter logic [31:0] TIMESTAMP   = 32'd0,
    parameter logic [31:0] VERSION     = 32'h0001_0000,
    parameter int          CLK_FREQ_HZ = 32'd50_000_000,
    parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    logic [31:0] scratch_r;
    logic [31:0] readdata_r;
    logic        readdatavalid_r;
    logic [31:0] rd_mux_s;
    logic        clear_s;
    logic        latch_hi_s;
    logic [31:0] lo_s;
    logic [31:0] hi_shadow_s;
    logic [31:0] seconds_s;

    sysid_uptime #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_uptime (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear_s),
        .latch_hi  (latch_hi_s),
        .lo        (lo_s),
        .hi_shadow (hi_shadow_s),
        .seconds   (seconds_s)
    );

    // Command decode: timer clear on control write, shadow latch on low-word read.
    always_comb begin
        clear_s    = 1'b0;
        latch_hi_s = 1'b0;
        if (write && (address == ADDR_STATUS) && writedata[CTRL_CLEAR_BIT]) begin
            clear_s = 1'b1;
        end else begin
            clear_s = 1'b0;
        end
        if (read && (address == ADDR_UPTIME_LO)) begin
            latch_hi_s = 1'b1;
        end else begin
            latch_hi_s = 1'b0;
        end
    end

    // Read mux sees current register values, so a same-cycle write is not visible.
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            ADDR_ID:        rd_mux_s = SYSTEM_ID;
            ADDR_TIMESTAMP: rd_mux_s = TIMESTAMP;
            ADDR_VERSION:   rd_mux_s = VERSION;
            ADDR_SCRATCH:   rd_mux_s = scratch_r;
            ADDR_UPTIME_LO: rd_mux_s = lo_s;
            ADDR_UPTIME_HI: rd_mux_s = hi_shadow_s;
            ADDR_SECONDS:   rd_mux_s = seconds_s;
            ADDR_STATUS: begin
                rd_mux_s = 32'd0;
                rd_mux_s[STATUS_PRESENT_BIT] = 1'b1;
            end
            default:        rd_mux_s = 32'd0;
        endcase
    end

    // Scratch register accepts byte-lane writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            scratch_r <= SCRATCH_RST;
        end else if (write && (address == ADDR_SCRATCH)) begin
            scratch_r <= byte_merge(scratch_r, writedata, byteenable);
        end else begin
            scratch_r <= scratch_r;
        end
    end

    // Registered read response; readdata holds its last value between reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_r      <= 32'd0;
            readdatavalid_r <= 1'b0;
        end else begin
            readdatavalid_r <= read;
            if (read) begin
                readdata_r <= rd_mux_s;
            end else begin
                readdata_r <= readdata_r;
            end
        end
    end

    assign readdata      = readdata_r;
    assign readdatavalid = readdatavalid_r;

endmodule

// File: tb/tb_sysid_regs.sv
// Directed bench for sysid_regs: identity words, scratch byte lanes, coherent
// uptime reads across a low-word wrap, seconds prescaler, clear, and reset.
module tb_sysid_regs;

    localparam logic [31:0] P_SYSTEM_ID   = 32'h58C2_F7FF;
    localparam logic [31:0] P_TIMESTAMP   = 32'd1489180159;
    localparam logic [31:0] P_VERSION     = 32'h0001_0000;
    localparam int          P_CLK_FREQ_HZ = 10;
    localparam logic [31:0] P_SCRATCH_RST = 32'hA5A5_0000;

    logic        clock;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    int total;
    int bad;

    sysid_regs #(
        .SYSTEM_ID   (P_SYSTEM_ID),
        .TIMESTAMP   (P_TIMESTAMP),
        .VERSION     (P_VERSION),
        .CLK_FREQ_HZ (P_CLK_FREQ_HZ),
        .SCRATCH_RST (P_SCRATCH_RST)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the read is sampled on the next posedge and the
    // response is checked at the following negedge.
    task automatic do_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        read    = 1'b1;
        @(negedge clock);
        read = 1'b0;
        check({tag, "_valid"}, {31'd0, readdatavalid}, 32'd1);
        check(tag, readdata, exp);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        address    = 3'd0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = 32'd0;
        byteenable = 4'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset state
        check("rst_readdata", readdata, 32'd0);
        check("rst_valid", {31'd0, readdatavalid}, 32'd0);

        // Identity words
        do_read("id", 3'd0, P_SYSTEM_ID);
        do_read("timestamp", 3'd1, 32'd1489180159);
        do_read("version", 3'd2, 32'h0001_0000);
        @(negedge clock);
        check("valid_one_cycle", {31'd0, readdatavalid}, 32'd0);
        do_read("status", 3'd7, 32'h0000_0001);

        // Scratch reset value and byte lanes
        do_read("scratch_rst", 3'd3, P_SCRATCH_RST);
        do_write(3'd3, 32'hDEAD_BEEF, 4'b1111);
        do_write(3'd3, 32'h0000_0012, 4'b0001);
        do_read("scratch_be", 3'd3, 32'hDEAD_BE12);
        do_write(3'd3, 32'h7700_0000, 4'b1000);
        do_read("scratch_be3", 3'd3, 32'h77AD_BE12);
        do_write(3'd0, 32'h1111_1111, 4'b1111);
        do_read("id_ro", 3'd0, 32'h58C2_F7FF);

        // Coherent uptime read, no wrap yet
        dut.u_uptime.uptime_r = 64'h0000_0000_FFFF_FFFE;
        do_read("up_lo_a", 3'd4, 32'hFFFF_FFFE);
        repeat (5) @(negedge clock);
        do_read("up_hi_a", 3'd5, 32'd0);

        // Same, but low word has wrapped by the time it is sampled
        dut.u_uptime.uptime_r = 64'h0000_0000_FFFF_FFFE;
        repeat (3) @(negedge clock);
        do_read("up_lo_b", 3'd4, 32'd1);
        repeat (5) @(negedge clock);
        do_read("up_hi_b", 3'd5, 32'd1);

        // Seconds: 35 cycles after reset at 10 cycles/second
        pulse_reset();
        repeat (35) @(negedge clock);
        do_read("seconds", 3'd6, 32'd3);
        // 36 edges elapsed; write sampled on edge 40 where prescaler is terminal
        repeat (3) @(negedge clock);
        do_write(3'd7, 32'h0000_0001, 4'b1111);
        do_read("sec_clear", 3'd6, 32'd0);
        do_read("up_after_clear", 3'd4, 32'd1);
        do_read("hi_after_clear", 3'd5, 32'd0);

        // Reset while a read is being presented
        do_write(3'd3, 32'hCAFE_F00D, 4'b1111);
        address = 3'd3;
        read    = 1'b1;
        reset   = 1'b1;
        @(negedge clock);
        read  = 1'b0;
        reset = 1'b0;
        check("rst_mid_valid", {31'd0, readdatavalid}, 32'd0);
        @(negedge clock);
        check("rst_idle_valid", {31'd0, readdatavalid}, 32'd0);
        do_read("up_restart", 3'd4, 32'd1);
        do_read("scratch_after_rst", 3'd3, P_SCRATCH_RST);

        // Simultaneous read and write of scratch
        address    = 3'd3;
        writedata  = 32'h1234_5678;
        byteenable = 4'b1111;
        write      = 1'b1;
        read       = 1'b1;
        @(negedge clock);
        write = 1'b0;
        read  = 1'b0;
        check("rw_old", readdata, P_SCRATCH_RST);
        check("rw_valid", {31'd0, readdatavalid}, 32'd1);
        do_read("rw_new", 3'd3, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sysid_regs.md
Name: sysid_regs

Overview:
- Parametrised successor to the single-word system-ID slave: an Avalon-MM slave bank of 8 × 32-bit words.
- Returns the build identity (ID, timestamp, version), a scratch register, a 64-bit cycle uptime counter with coherent high-word shadow, and a seconds counter.
- Sits on the Nios II data master's peripheral bus. Software uses it for identity checks, bus sanity tests and coarse timekeeping.

Parameters:
- SYSTEM_ID, 32'h58C2_F7FF, value returned at word 0.
- TIMESTAMP, 32'd0, build timestamp (Unix seconds) returned at word 1.
- VERSION, 32'h0001_0000, major[31:16]/minor[15:0] returned at word 2.
- CLK_FREQ_HZ, 50_000_000, clock cycles per second for the seconds prescaler (legal range ≥ 2).
- SCRATCH_RST, 32'h0000_0000, reset value of the scratch register.

Ports:
- clock  in  1  single system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word address.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high for exactly one cycle, one cycle after an accepted read.

Behaviour:
- No waitrequest: every read or write is accepted in the cycle it is presented. Fixed read latency 1.
- read and write asserted together: the write takes effect and the read returns the pre-write value.
- Reset values:
  - readdata = 0, readdatavalid = 0.
  - scratch = SCRATCH_RST.
  - uptime = 0, hi_shadow = 0.
  - prescaler = 0, seconds = 0.
- Word map (reads):
  - 0: SYSTEM_ID
  - 1: TIMESTAMP
  - 2: VERSION
  - 3: scratch
  - 4: uptime[31:0]. The same read also loads hi_shadow <= uptime[63:32] sampled in that cycle.
  - 5: hi_shadow
  - 6: seconds
  - 7: status. Bit 0 = 1 (feature present); bits 31:1 = 0.
- Writes:
  - Word 3: byte-lane write under byteenable.
  - Word 7, writedata[0] = 1: clear uptime, hi_shadow, prescaler and seconds to 0 on the next edge.
  - All other words are read-only; writes to them are ignored.
- uptime:
  - 64-bit counter, +1 every cycle, wraps from 2^64-1 to 0.
  - The clear write wins over the increment in the same cycle.
- Coherence: the pair (word 4, then word 5) always returns the 64-bit value captured by the word-4 read, regardless of intervening cycles.
- Prescaler:
  - Counts 0 to CLK_FREQ_HZ-1. At terminal count it wraps to 0 and seconds increments by 1.
  - seconds is 32-bit and wraps.
  - A clear coincident with terminal count: clear wins, so seconds reads 0.
- readdata reflects counter values as they are in the cycle read is sampled, before that cycle's increment.
- Reset mid-transaction: a read in flight during reset produces no readdatavalid. The block is idle the cycle after reset deasserts.
- No X on readdata at any time after the first reset.

Decomposition:
- Shared package sysid_pkg holds:
  - word-address constants ADDR_ID..ADDR_STATUS;
  - STATUS bit positions;
  - CTRL_CLEAR_BIT.
- One natural sub-module: sysid_uptime, containing the 64-bit counter, hi_shadow, prescaler and seconds. It takes a clear input and a latch_hi input, and outputs lo/hi_shadow/seconds.
- Register decode and read mux stay in the top level.

Test Plan:
- Reset, then read words 0/1/2 with SYSTEM_ID=32'h58C2F7FF, TIMESTAMP=32'd1489180159 → readdata 32'h58C2F7FF / 32'd1489180159 / 32'h00010000, each with readdatavalid one cycle after read.
- Write 32'hDEADBEEF to word 3 with byteenable 4'b1111, then write 32'h00000012 with byteenable 4'b0001 → read word 3 returns 32'hDEADBE12. Write to word 0 leaves it 32'h58C2F7FF.
- Force uptime to 32'hFFFF_FFFE (low word, hi 0) via hierarchical deposit. Read word 4, wait 5 cycles, read word 5 → 32'hFFFF_FFFE then 0. Repeat with the read 3 cycles later → low word has wrapped and hi_shadow = 1.
- CLK_FREQ_HZ=10: run 35 cycles after reset, then read word 6 → 3. Write word 7 = 1 at prescaler terminal count → next read of word 6 = 0 and word 4 is small (< 5).
- Assert reset for 1 cycle while a read of word 3 is pending → readdatavalid stays 0. Afterwards scratch = SCRATCH_RST and word 4 restarts from 0.
- read and write to word 3 in the same cycle with data 32'h12345678 → readdata returns the old value. A following read returns 32'h12345678.
